// File: rtl/median_stream_checker.sv
// median_stream_checker
//   Watches the sample stream fed to a median filter and the median it returns.
//   Keeps a golden sliding-window median, delays it to line up with the filter
//   output, compares the two, and counts samples and mismatches.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   enable       1 = take X/median this cycle, 0 = hold all state
//   X            sample presented to the filter
//   median       filter output for this cycle
//   golden       expected median, aligned to median
//   golden_valid golden is being compared this cycle
//   mismatch     one-cycle pulse on a failed compare
//   err_count    saturating mismatch counter
//   sample_count saturating count of enabled cycles since IDLE was left
//   pass         checking/warming up with no errors so far
//   halted       stopped on first error (ERR_STOP=1 only)
module median_stream_checker #(
    parameter int WIDTH    = 16,
    parameter int WIN      = 5,
    parameter int LATENCY  = 3,
    parameter int CNT_W    = 16,
    parameter int ERR_STOP = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] median,
    output logic [WIDTH-1:0] golden,
    output logic             golden_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count,
    output logic             pass,
    output logic             halted
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WARMUP = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam int MID = (WIN - 1) / 2;
    // Last warm-up count: first window is full and has reached the pipe output.
    localparam logic [CNT_W-1:0] WARM_END = CNT_W'(WIN + LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    logic [WIDTH-1:0] window_r     [0:WIN-1];      // oldest at index 0
    logic [WIDTH-1:0] sorted_r     [0:WIN-1];      // ascending copy of window_r
    logic [WIDTH-1:0] pipe_r       [0:LATENCY-1];  // alignment delay for the median
    logic [1:0]       state_r;
    logic [CNT_W-1:0] sample_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic             golden_valid_r;
    logic             mismatch_r;
    logic             pass_r;
    logic             halted_r;

    int               rm_idx_s;
    int               ins_pos_s;
    logic [WIDTH-1:0] rem_s        [0:WIN-1];
    logic [WIDTH-1:0] sorted_nxt_s [0:WIN-1];

    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] sample_cnt_nxt_s;
    logic [CNT_W-1:0] err_cnt_nxt_s;
    logic             mismatch_nxt_s;
    logic             advance_s;

    // Sorted-window update: drop one copy of the oldest sample, insert X above its equals.
    always_comb begin
        // Descending scan so the lowest matching slot wins; any copy of a duplicate is equivalent.
        rm_idx_s = WIN - 1;
        for (int i = WIN - 1; i >= 0; i--) begin
            rm_idx_s = (sorted_r[i] == window_r[0]) ? i : rm_idx_s;
        end
        for (int i = 0; i < WIN - 1; i++) begin
            rem_s[i] = (i < rm_idx_s) ? sorted_r[i] : sorted_r[i+1];
        end
        rem_s[WIN-1] = {WIDTH{1'b0}};
        // Counting "<=" places X after every equal value already present.
        ins_pos_s = 0;
        for (int i = 0; i < WIN - 1; i++) begin
            ins_pos_s = ins_pos_s + ((rem_s[i] <= X) ? 32'sd1 : 32'sd0);
        end
        for (int i = 0; i < WIN; i++) begin
            sorted_nxt_s[i] = (i < ins_pos_s)  ? rem_s[i] :
                              (i == ins_pos_s) ? X        :
                                                 rem_s[(i == 0) ? 0 : i - 1];
        end
    end

    // Control: state transitions, counters and the compare.
    always_comb begin
        state_nxt_s      = state_r;
        sample_cnt_nxt_s = sample_cnt_r;
        err_cnt_nxt_s    = err_cnt_r;
        mismatch_nxt_s   = 1'b0;
        advance_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (enable) begin
                    state_nxt_s      = S_WARMUP;
                    sample_cnt_nxt_s = CNT_ONE;
                    advance_s        = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WARMUP: begin
                if (enable) begin
                    advance_s        = 1'b1;
                    sample_cnt_nxt_s = sat_inc(sample_cnt_r);
                    if (sample_cnt_nxt_s >= WARM_END) begin
                        state_nxt_s = S_CHECK;
                    end else begin
                        state_nxt_s = S_WARMUP;
                    end
                end else begin
                    state_nxt_s = S_WARMUP;
                end
            end
            S_CHECK: begin
                if (enable) begin
                    advance_s        = 1'b1;
                    sample_cnt_nxt_s = sat_inc(sample_cnt_r);
                    if (median != pipe_r[LATENCY-1]) begin
                        mismatch_nxt_s = 1'b1;
                        err_cnt_nxt_s  = sat_inc(err_cnt_r);
                        state_nxt_s    = (ERR_STOP != 0) ? S_HALT : S_CHECK;
                    end else begin
                        state_nxt_s = S_CHECK;
                    end
                end else begin
                    state_nxt_s = S_CHECK;
                end
            end
            S_HALT: begin
                state_nxt_s = S_HALT;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Window, sorted copy and alignment pipe move only on an accepted sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIN; i++) begin
                window_r[i] <= {WIDTH{1'b0}};
                sorted_r[i] <= {WIDTH{1'b0}};
            end
            for (int k = 0; k < LATENCY; k++) begin
                pipe_r[k] <= {WIDTH{1'b0}};
            end
        end else if (advance_s) begin
            for (int i = 0; i < WIN - 1; i++) begin
                window_r[i] <= window_r[i+1];
            end
            window_r[WIN-1] <= X;
            for (int i = 0; i < WIN; i++) begin
                sorted_r[i] <= sorted_nxt_s[i];
            end
            pipe_r[0] <= sorted_nxt_s[MID];
            for (int k = 1; k < LATENCY; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
        end
    end

    // State, counters and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= S_IDLE;
            sample_cnt_r   <= {CNT_W{1'b0}};
            err_cnt_r      <= {CNT_W{1'b0}};
            golden_valid_r <= 1'b0;
            mismatch_r     <= 1'b0;
            pass_r         <= 1'b0;
            halted_r       <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            sample_cnt_r   <= sample_cnt_nxt_s;
            err_cnt_r      <= err_cnt_nxt_s;
            golden_valid_r <= (state_nxt_s == S_CHECK);
            mismatch_r     <= mismatch_nxt_s;
            pass_r         <= ((state_nxt_s == S_WARMUP) || (state_nxt_s == S_CHECK)) &&
                              (err_cnt_nxt_s == {CNT_W{1'b0}});
            halted_r       <= (state_nxt_s == S_HALT);
        end
    end

    assign golden       = pipe_r[LATENCY-1];
    assign golden_valid = golden_valid_r;
    assign mismatch     = mismatch_r;
    assign err_count    = err_cnt_r;
    assign sample_count = sample_cnt_r;
    assign pass         = pass_r;
    assign halted       = halted_r;

endmodule
